pattern_sequencer: RTL and testbench

Parametrised sequence store, playback and checking engine for the memory game. It holds the game pattern as up to `DEPTH` symbols of `SYM_W` bits. On request it plays the pattern on one-hot LEDs with programmable on/gap durations, then checks player input one symbol at a time in forward or reverse order. It sits between the mode FSMs (classic/time/reverse) and the LFSR and LED/button I/O. It replaces the fixed 75-bit shift register, display, comparator and input-handler path.

---
 rtl/pattern_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_pattern_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_sequencer.sv
// pattern_sequencer
//   Stores the memory-game pattern (up to DEPTH symbols of SYM_W bits), plays it
//   back on one-hot LEDs with ON_CYC lit / GAP_CYC dark cycles per symbol, then
//   checks player input one symbol at a time, first-to-last or last-to-first.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   clr               synchronous clear of pattern length and FSM (highest priority)
//   append/append_sym one-cycle pulse adding a symbol to the end of the pattern (IDLE only)
//   play/reverse      one-cycle pulse starting playback; reverse latched at start
//   in_valid/in_sym   player symbol, accepted only while ready is high
//   led               one-hot playback display
//   busy              playback or check in progress
//   ready             CHECK state, in_valid is accepted
//   len/full          current pattern length, len == DEPTH
//   step_ok           pulse: checked symbol matched
//   round_done        pulse: whole pattern matched (together with step_ok)
//   mismatch          pulse: checked symbol was wrong
//   dbg_state         current FSM state (IDLE=0, SHOW_ON=1, SHOW_GAP=2, CHECK=3)
//
// Handshake: in_valid is a one-cycle strobe. A symbol is consumed on a rising
// edge where in_valid and ready are both high; in_valid with ready low is
// dropped. There is no back-pressure on the outputs: each result pulse lasts
// exactly one cycle, the cycle after the consuming edge.

module pattern_sequencer #(
    parameter int SYM_W   = 3,
    parameter int DEPTH   = 25,
    parameter int ON_CYC  = 4,
    parameter int GAP_CYC = 2,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  append,
    input  logic [SYM_W-1:0]      append_sym,
    input  logic                  play,
    input  logic                  reverse,
    input  logic                  in_valid,
    input  logic [SYM_W-1:0]      in_sym,
    output logic [2**SYM_W-1:0]   led,
    output logic                  busy,
    output logic                  ready,
    output logic [CNT_W-1:0]      len,
    output logic                  full,
    output logic                  step_ok,
    output logic                  round_done,
    output logic                  mismatch,
    output logic [1:0]            dbg_state
);

    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TMR_MAX = (ON_CYC > GAP_CYC) ? ON_CYC : GAP_CYC;
    // Timer counts down from duration-1 to 0, so it only needs to hold TMR_MAX-1.
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [TMR_W-1:0] ON_LOAD  = TMR_W'(ON_CYC - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] LEN_MAX  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SHOW_ON  = 2'd1,
        S_SHOW_GAP = 2'd2,
        S_CHECK    = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               rev_q, rev_d;
    logic               step_ok_q, step_ok_d;
    logic               round_done_q, round_done_d;
    logic               mismatch_q, mismatch_d;
    logic               mem_we;
    logic [SYM_W-1:0]   mem_q [DEPTH];

    logic [SYM_W-1:0]   cur_sym;
    logic [CNT_W-1:0]   last_idx;
    logic               full_w;

    // idx doubles as the playback index and the check pointer.
    assign cur_sym  = mem_q[idx_q[AW-1:0]];
    assign last_idx = len_q - CNT_ONE;
    assign full_w   = (len_q == LEN_MAX);

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        idx_d        = idx_q;
        tmr_d        = tmr_q;
        rev_d        = rev_q;
        step_ok_d    = 1'b0;
        round_done_d = 1'b0;
        mismatch_d   = 1'b0;
        mem_we       = 1'b0;

        if (clr) begin
            state_d = S_IDLE;
            len_d   = '0;
            idx_d   = '0;
            tmr_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (append && !full_w) begin
                        mem_we = 1'b1;
                        len_d  = len_q + CNT_ONE;
                    end
                    // Uses the post-append length so append+play plays the new symbol.
                    if (play && (len_d != '0)) begin
                        rev_d   = reverse;
                        idx_d   = '0;
                        tmr_d   = ON_LOAD;
                        state_d = S_SHOW_ON;
                    end
                end
                S_SHOW_ON: begin
                    if (tmr_q == '0) begin
                        tmr_d   = GAP_LOAD;
                        state_d = S_SHOW_GAP;
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
                end
                S_SHOW_GAP: begin
                    if (tmr_q != '0) begin
                        tmr_d = tmr_q - 1'b1;
                    end else if (idx_q == last_idx) begin
                        tmr_d   = '0;
                        idx_d   = rev_q ? last_idx : '0;
                        state_d = S_CHECK;
                    end else begin
                        idx_d   = idx_q + CNT_ONE;
                        tmr_d   = ON_LOAD;
                        state_d = S_SHOW_ON;
                    end
                end
                S_CHECK: begin
                    if (in_valid) begin
                        if (in_sym == cur_sym) begin
                            step_ok_d = 1'b1;
                            if (rev_q ? (idx_q == '0) : (idx_q == last_idx)) begin
                                round_done_d = 1'b1;
                                idx_d        = '0;
                                state_d      = S_IDLE;
                            end else begin
                                idx_d = rev_q ? (idx_q - CNT_ONE) : (idx_q + CNT_ONE);
                            end
                        end else begin
                            mismatch_d = 1'b1;
                            idx_d      = '0;
                            state_d    = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            idx_q        <= '0;
            tmr_q        <= '0;
            rev_q        <= 1'b0;
            step_ok_q    <= 1'b0;
            round_done_q <= 1'b0;
            mismatch_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            tmr_q        <= tmr_d;
            rev_q        <= rev_d;
            step_ok_q    <= step_ok_d;
            round_done_q <= round_done_d;
            mismatch_q   <= mismatch_d;
        end
    end

    // Pattern storage needs no reset; len decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[len_q[AW-1:0]] <= append_sym;
        end
    end

    // LED is decoded from registered state and storage only.
    always_comb begin
        led = '0;
        if (state_q == S_SHOW_ON) begin
            led[cur_sym] = 1'b1;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign ready      = (state_q == S_CHECK);
    assign len        = len_q;
    assign full       = full_w;
    assign step_ok    = step_ok_q;
    assign round_done = round_done_q;
    assign mismatch   = mismatch_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Bench for pattern_sequencer with SYM_W=3, DEPTH=4, ON_CYC=3, GAP_CYC=2.
// Drivers push expected LED frames and result pulses into queues; a monitor on
// the falling edge pops and compares whenever the DUT shows playback or a pulse.

module tb_pattern_sequencer;

    localparam int SYM_W   = 3;
    localparam int DEPTH   = 4;
    localparam int ON_CYC  = 3;
    localparam int GAP_CYC = 2;
    localparam int CNT_W   = 3;

    // Result pulse encoding: {mismatch, round_done, step_ok}
    localparam logic [2:0] EV_STEP = 3'b001;
    localparam logic [2:0] EV_DONE = 3'b011;
    localparam logic [2:0] EV_MISS = 3'b100;

    logic             clk;
    logic             rst_n;
    logic             clr;
    logic             append;
    logic [SYM_W-1:0] append_sym;
    logic             play;
    logic             reverse;
    logic             in_valid;
    logic [SYM_W-1:0] in_sym;
    logic [7:0]       led;
    logic             busy;
    logic             ready;
    logic [CNT_W-1:0] len;
    logic             full;
    logic             step_ok;
    logic             round_done;
    logic             mismatch;
    logic [1:0]       dbg_state;

    logic [7:0] exp_q[$];
    logic [2:0] ev_q[$];
    logic [7:0] mon_led;
    logic [2:0] mon_ev;

    int vectors;
    int miscompares;

    pattern_sequencer #(
        .SYM_W  (SYM_W),
        .DEPTH  (DEPTH),
        .ON_CYC (ON_CYC),
        .GAP_CYC(GAP_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .append    (append),
        .append_sym(append_sym),
        .play      (play),
        .reverse   (reverse),
        .in_valid  (in_valid),
        .in_sym    (in_sym),
        .led       (led),
        .busy      (busy),
        .ready     (ready),
        .len       (len),
        .full      (full),
        .step_ok   (step_ok),
        .round_done(round_done),
        .mismatch  (mismatch),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- compare helper ----------------
    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy && !ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL led_unexpected: got 0x%0h, expected no playback", led);
                end else begin
                    mon_led = exp_q.pop_front();
                    check("led_frame", int'(led), int'(mon_led));
                end
            end
            if (step_ok || round_done || mismatch) begin
                if (ev_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL pulse_unexpected: got %b, expected none", {mismatch, round_done, step_ok});
                end else begin
                    mon_ev = ev_q.pop_front();
                    check("result_pulse", int'({mismatch, round_done, step_ok}), int'(mon_ev));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_show(input logic [7:0] onehot);
        repeat (ON_CYC) exp_q.push_back(onehot);
        repeat (GAP_CYC) exp_q.push_back(8'h00);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic do_append(input logic [2:0] s);
        append     = 1'b1;
        append_sym = s;
        @(negedge clk);
        append = 1'b0;
    endtask

    // Starts playback (optionally with a same-cycle append) and checks how many
    // cycles pass from the play edge until ready rises.
    task automatic do_play(input logic rev, input int exp_len, input logic app, input logic [2:0] s);
        int n;
        play       = 1'b1;
        reverse    = rev;
        append     = app;
        append_sym = s;
        @(negedge clk);
        play   = 1'b0;
        append = 1'b0;
        n = 0;
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ready_latency", n, exp_len * (ON_CYC + GAP_CYC));
    endtask

    task automatic send(input logic [2:0] s, input logic [2:0] ev);
        ev_q.push_back(ev);
        in_valid = 1'b1;
        in_sym   = s;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic summary();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        repeat (20000) @(posedge clk);
        miscompares++;
        $display("FAIL watchdog: got timeout, expected bench completion");
        summary();
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b1;
        clr         = 1'b0;
        append      = 1'b0;
        append_sym  = '0;
        play        = 1'b0;
        reverse     = 1'b0;
        in_valid    = 1'b0;
        in_sym      = '0;

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        check("rst_led", int'(led), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(ready), 0);
        check("rst_len", int'(len), 0);
        check("rst_full", int'(full), 0);
        check("rst_pulses", int'({mismatch, round_done, step_ok}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Playback of 5,2,7 and forward check
        do_append(3'd5);
        do_append(3'd2);
        do_append(3'd7);
        check("len_after_3", int'(len), 3);
        push_show(8'h20);
        push_show(8'h04);
        push_show(8'h80);
        do_play(1'b0, 3, 1'b0, 3'd0);
        send(3'd5, EV_STEP);
        send(3'd2, EV_STEP);
        send(3'd7, EV_DONE);
        check("fwd_done_ready", int'(ready), 0);
        check("fwd_done_busy", int'(busy), 0);

        // Forward round with a wrong second symbol
        push_show(8'h20);
        push_show(8'h04);
        push_show(8'h80);
        do_play(1'b0, 3, 1'b0, 3'd0);
        send(3'd5, EV_STEP);
        send(3'd3, EV_MISS);
        check("fwd_miss_ready", int'(ready), 0);
        check("fwd_miss_busy", int'(busy), 0);
        check("fwd_miss_len", int'(len), 3);

        // Reverse check 7,2,5
        push_show(8'h20);
        push_show(8'h04);
        push_show(8'h80);
        do_play(1'b1, 3, 1'b0, 3'd0);
        send(3'd7, EV_STEP);
        send(3'd2, EV_STEP);
        send(3'd5, EV_DONE);
        check("rev_done_busy", int'(busy), 0);

        // Reverse with the forward-first symbol is wrong
        push_show(8'h20);
        push_show(8'h04);
        push_show(8'h80);
        do_play(1'b1, 3, 1'b0, 3'd0);
        send(3'd5, EV_MISS);
        check("rev_miss_ready", int'(ready), 0);
        check("rev_miss_len", int'(len), 3);

        // Fill to DEPTH, then an extra append is ignored
        do_clr();
        check("clr_len", int'(len), 0);
        do_append(3'd1);
        do_append(3'd2);
        do_append(3'd3);
        do_append(3'd4);
        check("full_flag", int'(full), 1);
        check("full_len", int'(len), 4);
        do_append(3'd6);
        check("overfull_len", int'(len), 4);
        check("overfull_full", int'(full), 1);
        push_show(8'h02);
        push_show(8'h04);
        push_show(8'h08);
        push_show(8'h10);
        do_play(1'b0, 4, 1'b0, 3'd0);
        send(3'd1, EV_STEP);
        send(3'd2, EV_STEP);
        send(3'd3, EV_STEP);
        send(3'd4, EV_DONE);

        // append and play in the same cycle with len=2
        do_clr();
        do_append(3'd1);
        do_append(3'd2);
        check("len_before_combo", int'(len), 2);
        push_show(8'h02);
        push_show(8'h04);
        push_show(8'h40);
        do_play(1'b0, 3, 1'b1, 3'd6);
        check("len_after_combo", int'(len), 3);
        send(3'd1, EV_STEP);
        send(3'd2, EV_STEP);
        send(3'd6, EV_DONE);

        // clr during the first lit cycle of symbol 2
        push_show(8'h02);
        exp_q.push_back(8'h04);
        play    = 1'b1;
        reverse = 1'b0;
        @(negedge clk);
        play = 1'b0;
        repeat (5) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_led", int'(led), 0);
        check("clr_busy", int'(busy), 0);
        check("clr_len2", int'(len), 0);
        in_valid = 1'b1;
        in_sym   = 3'd1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("clr_no_pulse", int'({mismatch, round_done, step_ok}), 0);
        play = 1'b1;
        @(negedge clk);
        play = 1'b0;
        check("clr_play_ignored", int'(busy), 0);
        @(negedge clk);
        check("clr_play_ignored2", int'(busy), 0);

        // Asynchronous reset in the middle of playback
        do_append(3'd3);
        exp_q.push_back(8'h08);
        exp_q.push_back(8'h08);
        play = 1'b1;
        @(negedge clk);
        play = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_led", int'(led), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_ready", int'(ready), 0);
        check("mid_rst_len", int'(len), 0);
        check("mid_rst_full", int'(full), 0);
        check("mid_rst_pulses", int'({mismatch, round_done, step_ok}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_len", int'(len), 0);
        check("post_rst_full", int'(full), 0);
        check("post_rst_busy", int'(busy), 0);

        repeat (2) @(negedge clk);
        check("led_queue_left", exp_q.size(), 0);
        check("pulse_queue_left", ev_q.size(), 0);

        summary();
        $finish;
    end

endmodule
